traffic_display: RTL and testbench

Consumer side of the traffic controller's status interface. It takes the controller's phase code and the two per-lane countdown values, and drives the physical lamps and a 4-digit multiplexed 7-segment countdown display. It sits between the auto-mode controller and the board pins. It converts binary countdowns to decimal with a sequential shift-add-3 converter, and shows a blinking-yellow fault pattern for any unrecognised phase code.

---
 rtl/traffic_pkg.sv | 47 ++++
 rtl/traffic_display_if.sv | 12 +
 rtl/bcd_conv7.sv | 48 ++++
 rtl/traffic_display.sv | 168 ++++++++++++++++
 tb/tb_traffic_display.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic display: phase codes, lamp patterns,
// conversion FSM states and the 7-segment lookup.
package traffic_pkg;

  // Controller phase codes carried on the status bus
  localparam logic [2:0] PH_GR = 3'd3;
  localparam logic [2:0] PH_YR = 3'd4;
  localparam logic [2:0] PH_RG = 3'd5;
  localparam logic [2:0] PH_RY = 3'd6;

  // Lamp patterns {R,Y,G}, active-high
  localparam logic [2:0] LAMP_RED = 3'b100;
  localparam logic [2:0] LAMP_YEL = 3'b010;
  localparam logic [2:0] LAMP_GRN = 3'b001;

  // Largest countdown the two-digit display can show
  localparam logic [6:0] TIME_MAX = 7'd99;

  // Segment pattern {g,f,e,d,c,b,a}, active-low, with every segment dark
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    CONV_LOAD   = 2'd0,
    CONV_SHIFT  = 2'd1,
    CONV_COMMIT = 2'd2
  } conv_state_t;

  // Active-low segment pattern for a BCD digit; non-decimal codes go dark
  function automatic logic [6:0] seg7(input logic [3:0] digit);
    logic [6:0] s;
    case (digit)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/traffic_display_if.sv
// Status bus from the traffic controller to the display.
// There is no valid/ready handshake on this bus: the controller drives
// state and both countdowns as levels, and the display samples them on
// every clock edge, so the master may change them at any time.
interface traffic_display_if;
  logic [2:0] state;
  logic [6:0] timeLane1;
  logic [6:0] timeLane2;

  modport master (output state, timeLane1, timeLane2);
  modport slave  (input  state, timeLane1, timeLane2);
endinterface

// File: rtl/bcd_conv7.sv
// Sequential double-dabble: 7-bit binary (0..99) to two BCD digits,
// one shift-add-3 step per cycle, seven steps after start.
module bcd_conv7 (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [6:0] bin,
  output logic [7:0] bcd,
  output logic       done
);

  // {tens, ones, remaining binary bits}
  logic [14:0] sr;
  logic [2:0]  step;
  logic        busy;

  // One double-dabble step: correct each BCD nibble, then shift left.
  // Inputs never exceed 99, so the tens nibble never needs a carry out.
  function automatic logic [14:0] dabble(input logic [14:0] v);
    logic [14:0] a;
    a = v;
    if (a[10:7] >= 4'd5)  a[10:7]  = a[10:7]  + 4'd3;
    if (a[14:11] >= 4'd5) a[14:11] = a[14:11] + 4'd3;
    return {a[13:0], 1'b0};
  endfunction

  // Load on start, then run seven steps; reset abandons any conversion
  always_ff @(posedge clk) begin
    if (!reset) begin
      sr   <= '0;
      step <= '0;
      busy <= 1'b0;
    end else if (start) begin
      sr   <= {8'd0, bin};
      step <= '0;
      busy <= 1'b1;
    end else if (busy) begin
      sr   <= dabble(sr);
      step <= step + 3'd1;
      if (step == 3'd6) busy <= 1'b0;
    end
  end

  assign bcd  = sr[14:7];
  // High during the cycle whose closing edge performs the last step
  assign done = busy && (step == 3'd6);

endmodule

// File: rtl/traffic_display.sv
// Drives lane lamps and a 4-digit multiplexed countdown display from the
// controller's status bus. Unknown phase codes show a blinking-yellow fault.
module traffic_display
  import traffic_pkg::*;
#(
  parameter int SCAN_DIV  = 1000,
  parameter int BLINK_DIV = 25_000_000
) (
  input  logic                clk,
  input  logic                reset,
  traffic_display_if.slave    status,
  output logic [2:0]          lamp1,
  output logic [2:0]          lamp2,
  output logic [6:0]          seg,
  output logic [3:0]          an,
  output conv_state_t         dbg_state
);

  localparam int SCAN_W  = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
  localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  conv_state_t        conv_state;
  logic [7:0]         digits1, digits2;
  logic               valid;
  logic [6:0]         t1_clamped, t2_clamped;
  logic [7:0]         bcd1, bcd2;
  logic               done1, done2;
  logic               start;
  logic [BLINK_W-1:0] blink_cnt;
  logic               blink_phase;
  logic [SCAN_W-1:0]  scan_cnt;
  logic [1:0]         scan_idx;
  logic               fault;
  logic [3:0]         cur_digit;
  logic               cur_blank;

  // Saturate countdowns so the converter only ever sees 0..99
  always_comb begin
    t1_clamped = (status.timeLane1 > TIME_MAX) ? TIME_MAX : status.timeLane1;
    t2_clamped = (status.timeLane2 > TIME_MAX) ? TIME_MAX : status.timeLane2;
  end

  assign start     = (conv_state == CONV_LOAD);
  assign dbg_state = conv_state;

  bcd_conv7 u_conv1 (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .bin   (t1_clamped),
    .bcd   (bcd1),
    .done  (done1)
  );

  bcd_conv7 u_conv2 (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .bin   (t2_clamped),
    .bcd   (bcd2),
    .done  (done2)
  );

  // Conversion loop LOAD -> SHIFT x7 -> COMMIT; results land only in COMMIT
  always_ff @(posedge clk) begin
    if (!reset) begin
      conv_state <= CONV_LOAD;
      digits1    <= '0;
      digits2    <= '0;
      valid      <= 1'b0;
    end else begin
      case (conv_state)
        CONV_LOAD:   conv_state <= CONV_SHIFT;
        CONV_SHIFT:  if (done1 && done2) conv_state <= CONV_COMMIT;
        CONV_COMMIT: begin
          digits1    <= bcd1;
          digits2    <= bcd2;
          valid      <= 1'b1;
          conv_state <= CONV_LOAD;
        end
        default:     conv_state <= CONV_LOAD;
      endcase
    end
  end

  // Free-running fault blink; keeps counting across fault entry and exit
  always_ff @(posedge clk) begin
    if (!reset) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (blink_cnt == BLINK_W'(BLINK_DIV - 1)) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  // Digit scan; held at the lane-1 tens digit until the first result exists
  always_ff @(posedge clk) begin
    if (!reset) begin
      scan_cnt <= '0;
      scan_idx <= 2'd3;
    end else if (valid) begin
      if (scan_cnt == SCAN_W'(SCAN_DIV - 1)) begin
        scan_cnt <= '0;
        scan_idx <= scan_idx - 2'd1;
      end else begin
        scan_cnt <= scan_cnt + 1'b1;
      end
    end
  end

  // Recognised phase codes; anything else is a fault
  always_comb begin
    fault = 1'b1;
    case (status.state)
      PH_GR, PH_YR, PH_RG, PH_RY: fault = 1'b0;
      default:                    fault = 1'b1;
    endcase
  end

  // Pick the digit under scan; tens digits of zero are blanked
  always_comb begin
    cur_digit = 4'd0;
    cur_blank = 1'b0;
    case (scan_idx)
      2'd3: begin cur_digit = digits1[7:4]; cur_blank = (digits1[7:4] == 4'd0); end
      2'd2: begin cur_digit = digits1[3:0]; cur_blank = 1'b0; end
      2'd1: begin cur_digit = digits2[7:4]; cur_blank = (digits2[7:4] == 4'd0); end
      default: begin cur_digit = digits2[3:0]; cur_blank = 1'b0; end
    endcase
  end

  // Registered lamp decode; reset leaves both lanes red
  always_ff @(posedge clk) begin
    if (!reset) begin
      lamp1 <= LAMP_RED;
      lamp2 <= LAMP_RED;
    end else begin
      case (status.state)
        PH_GR:   begin lamp1 <= LAMP_GRN; lamp2 <= LAMP_RED; end
        PH_YR:   begin lamp1 <= LAMP_YEL; lamp2 <= LAMP_RED; end
        PH_RG:   begin lamp1 <= LAMP_RED; lamp2 <= LAMP_GRN; end
        PH_RY:   begin lamp1 <= LAMP_RED; lamp2 <= LAMP_YEL; end
        default: begin
          lamp1 <= {1'b0, blink_phase, 1'b0};
          lamp2 <= {1'b0, blink_phase, 1'b0};
        end
      endcase
    end
  end

  // Registered display drive; dark during fault or before the first result
  always_ff @(posedge clk) begin
    if (!reset) begin
      an  <= 4'b1111;
      seg <= SEG_BLANK;
    end else if (fault || !valid) begin
      an  <= 4'b1111;
      seg <= SEG_BLANK;
    end else begin
      an  <= ~(4'b0001 << scan_idx);
      seg <= cur_blank ? SEG_BLANK : seg7(cur_digit);
    end
  end

endmodule

// File: tb/tb_traffic_display.sv
// Directed bench for traffic_display with a short scan and blink period.
module tb_traffic_display;
  import traffic_pkg::*;

  localparam int SCAN_DIV  = 4;
  localparam int BLINK_DIV = 8;

  // Hand-written active-low segment codes {g..a}
  localparam logic [6:0] S_0  = 7'h40;
  localparam logic [6:0] S_1  = 7'h79;
  localparam logic [6:0] S_2  = 7'h24;
  localparam logic [6:0] S_3  = 7'h30;
  localparam logic [6:0] S_4  = 7'h19;
  localparam logic [6:0] S_5  = 7'h12;
  localparam logic [6:0] S_7  = 7'h78;
  localparam logic [6:0] S_9  = 7'h10;
  localparam logic [6:0] S_BL = 7'h7F;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [2:0]  lamp1, lamp2;
  logic [6:0]  seg;
  logic [3:0]  an;
  conv_state_t dbg_state;

  traffic_display_if status_bus ();

  traffic_display #(
    .SCAN_DIV  (SCAN_DIV),
    .BLINK_DIV (BLINK_DIV)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .status    (status_bus.slave),
    .lamp1     (lamp1),
    .lamp2     (lamp2),
    .seg       (seg),
    .an        (an),
    .dbg_state (dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;      // edges since the most recent reset release
  logic [10:0] exp_q[$]; // expected {an, seg} per cycle

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Advance one edge and settle before sampling
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic set_phase(input logic [2:0] p);
    status_bus.state = p;
  endtask

  task automatic set_times(input logic [6:0] t1, input logic [6:0] t2);
    status_bus.timeLane1 = t1;
    status_bus.timeLane2 = t2;
  endtask

  // Expected full scan starting at the first lane-1 tens cycle
  task automatic push_scan(input logic [6:0] s3, input logic [6:0] s2,
                           input logic [6:0] s1, input logic [6:0] s0);
    for (int r = 0; r < SCAN_DIV; r++) exp_q.push_back({4'b0111, s3});
    for (int r = 0; r < SCAN_DIV; r++) exp_q.push_back({4'b1011, s2});
    for (int r = 0; r < SCAN_DIV; r++) exp_q.push_back({4'b1101, s1});
    for (int r = 0; r < SCAN_DIV; r++) exp_q.push_back({4'b1110, s0});
  endtask

  // Compare the current sample and following cycles against the queue
  task automatic run_scan(input string tag);
    logic [10:0] e;
    bit first;
    first = 1'b1;
    while (exp_q.size() > 0) begin
      if (!first) tick();
      first = 1'b0;
      e = exp_q.pop_front();
      check({tag, "_an"},  an,  e[10:7]);
      check({tag, "_seg"}, seg, e[6:0]);
    end
  endtask

  // Let a new value propagate, then align to the start of a scan sweep
  task automatic settle_and_sync();
    for (int i = 0; i < 20; i++) tick();
    for (int i = 0; i < 24 && an !== 4'b1110; i++) tick();
    for (int i = 0; i < 8 && an !== 4'b0111; i++) tick();
  endtask

  task automatic scan_vector(input string tag, input logic [6:0] t1, input logic [6:0] t2,
                             input logic [6:0] s3, input logic [6:0] s2,
                             input logic [6:0] s1, input logic [6:0] s0);
    set_times(t1, t2);
    settle_and_sync();
    push_scan(s3, s2, s1, s0);
    run_scan(tag);
  endtask

  initial begin
    logic y;
    set_phase(PH_GR);
    set_times(7'd42, 7'd7);

    // Reset held for three edges
    reset = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    check("rst_lamp1", lamp1, 3'b100);
    check("rst_lamp2", lamp2, 3'b100);
    check("rst_an",    an,    4'b1111);
    check("rst_seg",   seg,   7'h7F);
    check("rst_fsm",   dbg_state, CONV_LOAD);

    // Release: display stays dark until the first commit registers
    reset = 1'b1;
    cyc = 0;
    tick();
    check("gr_lamp1", lamp1, 3'b001);
    check("gr_lamp2", lamp2, 3'b100);
    check("shift_fsm", dbg_state, CONV_SHIFT);
    while (cyc < 9) begin
      check("dark_an", an, 4'b1111);
      tick();
    end
    check("dark_an9", an, 4'b1111);
    check("dark_seg9", seg, 7'h7F);
    tick();
    push_scan(S_4, S_2, S_BL, S_7);
    push_scan(S_4, S_2, S_BL, S_7);
    run_scan("scan42_7");

    // Lamp decode, each one edge after the phase change
    set_phase(PH_YR); tick();
    check("yr_lamp1", lamp1, 3'b010);
    check("yr_lamp2", lamp2, 3'b100);
    set_phase(PH_RG); tick();
    check("rg_lamp1", lamp1, 3'b100);
    check("rg_lamp2", lamp2, 3'b001);
    set_phase(PH_RY); tick();
    check("ry_lamp1", lamp1, 3'b100);
    check("ry_lamp2", lamp2, 3'b010);
    set_phase(PH_GR); tick();
    check("gr2_lamp1", lamp1, 3'b001);
    check("gr2_lamp2", lamp2, 3'b100);

    // Clamp and digit edges
    scan_vector("clamp120_0", 7'd120, 7'd0,   S_9, S_9, S_BL, S_0);
    scan_vector("ten_100",    7'd10,  7'd100, S_1, S_0, S_9,  S_9);
    scan_vector("nine_99",    7'd9,   7'd99,  S_BL, S_9, S_9, S_9);

    // Fault: blink phase flips every BLINK_DIV edges since release,
    // lamps show the phase held before the sampling edge
    set_phase(3'd0);
    for (int i = 0; i < 3 * BLINK_DIV; i++) begin
      tick();
      y = (((cyc - 1) / BLINK_DIV) % 2) == 1;
      check("fault_lamp1", lamp1, {1'b0, y, 1'b0});
      check("fault_lamp2", lamp2, {1'b0, y, 1'b0});
      check("fault_an",    an,    4'b1111);
    end
    set_phase(PH_GR); tick();
    check("exit_lamp1", lamp1, 3'b001);
    check("exit_lamp2", lamp2, 3'b100);

    // Reset in the middle of a conversion
    set_times(7'd42, 7'd3);
    for (int i = 0; i < 10 && dbg_state !== CONV_SHIFT; i++) tick();
    check("mid_in_shift", dbg_state, CONV_SHIFT);
    set_times(7'd55, 7'd3);
    reset = 1'b0;
    tick();
    check("mid_rst_an",    an,    4'b1111);
    check("mid_rst_seg",   seg,   7'h7F);
    check("mid_rst_lamp1", lamp1, 3'b100);
    check("mid_rst_fsm",   dbg_state, CONV_LOAD);
    reset = 1'b1;
    cyc = 0;
    while (cyc < 9) tick();
    check("mid_dark_an9", an, 4'b1111);
    tick();
    push_scan(S_5, S_5, S_BL, S_3);
    run_scan("after_mid_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
